// File: rtl/hacd_pkg.sv
// Shared types and constants for the decompression page writer.
// Holds the FSM state type, page geometry constants and the AXI write payload struct.
// No logic; imported by the page writer and its handshake tracker.
package hacd_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 512;
    localparam int PG_LINES   = 64;   // 4 KB page / 64 B cacheline
    localparam int PAGE_SHIFT = 12;   // byte offset bits within a page
    localparam int LINE_SHIFT = 6;    // byte offset bits within a cacheline

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE,
        ST_BUS_ERROR
    } pgwr_state_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0]   addr;
        logic [7:0]              awlen;
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
    } axi_wr_pld_t;

endpackage

// File: rtl/hawk_axi_wr_hs.sv
// Per-line AW/W dual-handshake tracker: records which of the two channels has completed.
// Latency: flags set on the edge of each handshake; o_both_done is combinational (same cycle).
// Backpressure: none of its own; it only observes valid/ready pairs. Ports: i_clr wipes both flags.
module hawk_axi_wr_hs (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clr,
    input  logic i_awvalid,
    input  logic i_awready,
    input  logic i_wvalid,
    input  logic i_wready,
    output logic o_aw_done,
    output logic o_w_done,
    output logic o_both_done
);
    logic r_aw_done;
    logic r_w_done;
    logic w_aw_hs;
    logic w_w_hs;

    assign w_aw_hs = i_awvalid & i_awready;
    assign w_w_hs  = i_wvalid & i_wready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (i_clr) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
        end
    end

    // Counts a handshake completing this cycle, so both channels may finish together or apart.
    assign o_both_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign o_aw_done   = r_aw_done;
    assign o_w_done    = r_w_done;

endmodule

// File: rtl/hawk_decomp_pgwr.sv
// Page writer: drains 64 decompressed lines from the show-ahead FIFO as single-beat AXI4 writes.
// Latency: 2 cycles per line best case; done_o pulses 129 cycles after start_i is sampled.
// Backpressure: one write outstanding; stalls with valids low on FIFO empty, holds valids on !ready.
// Ports: start_i/dst_base_i request, wdfifo_* FIFO head/pop, aw*/w*/b* AXI write, busy_o/done_o/err_o status.
module hawk_decomp_pgwr
    import hacd_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LINES  = PG_LINES
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   dst_base_i,
    input  logic                wdfifo_empty_i,
    input  logic [DATA_W-1:0]   wdfifo_rdata_i,
    output logic                wdfifo_pop_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [7:0]          awlen_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    input  logic                bvalid_i,
    input  logic [1:0]          bresp_i,
    output logic                bready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);
    localparam int LINE_W  = $clog2(LINES);
    localparam int PAGE_W  = ADDR_W - PAGE_SHIFT;
    localparam int LFIELD_W = PAGE_SHIFT - LINE_SHIFT;

    pgwr_state_t        r_state;
    pgwr_state_t        w_state_nxt;
    logic [PAGE_W-1:0]  r_page;
    logic [LINE_W-1:0]  r_line_cnt;
    logic               r_err;

    logic w_hs_clr, w_start, w_line_adv, w_err_set;
    logic w_aw_done, w_w_done, w_both_done;
    logic w_in_req, w_awvalid, w_wvalid, w_last_line;
    logic w_unused_ok;
    axi_wr_pld_t w_pld;

    // The page offset of the caller's base address is meaningless; writes always start at line 0.
    assign w_unused_ok = ^dst_base_i[PAGE_SHIFT-1:0];

    assign w_last_line = (r_line_cnt == LINE_W'(LINES - 1));

    // Valids are Moore: state, flags and FIFO level only. AW may go on an empty FIFO once the
    // beat has already left, so a raised AW never drops before its handshake.
    assign w_in_req  = (r_state == ST_WR_REQ);
    assign w_wvalid  = w_in_req & ~w_w_done & ~wdfifo_empty_i;
    assign w_awvalid = w_in_req & ~w_aw_done & (~wdfifo_empty_i | w_w_done);

    hawk_axi_wr_hs u_hs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_clr       (w_hs_clr),
        .i_awvalid   (w_awvalid),
        .i_awready   (awready_i),
        .i_wvalid    (w_wvalid),
        .i_wready    (wready_i),
        .o_aw_done   (w_aw_done),
        .o_w_done    (w_w_done),
        .o_both_done (w_both_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hs_clr    = 1'b0;
        w_start     = 1'b0;
        w_line_adv  = 1'b0;
        w_err_set   = 1'b0;
        bready_o    = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_start     = 1'b1;
                    w_hs_clr    = 1'b1;
                    w_state_nxt = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (w_both_done) w_state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    if (bresp_i == 2'b00) begin
                        if (w_last_line) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_line_adv  = 1'b1;
                            w_hs_clr    = 1'b1;
                            w_state_nxt = ST_WR_REQ;
                        end
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_BUS_ERROR;
                    end
                end
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_BUS_ERROR: begin
                // Terminal until reset.
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_page     <= '0;
            r_line_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_start) begin
                r_page     <= dst_base_i[ADDR_W-1:PAGE_SHIFT];
                r_line_cnt <= '0;
            end else if (w_line_adv) begin
                r_line_cnt <= r_line_cnt + LINE_W'(1);
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

    // Payload is zeroed while W is idle so all outputs read 0 out of reset.
    always_comb begin
        w_pld.addr  = {r_page, LFIELD_W'(r_line_cnt), {LINE_SHIFT{1'b0}}};
        w_pld.awlen = 8'd0;
        w_pld.data  = w_wvalid ? wdfifo_rdata_i : '0;
        w_pld.strb  = w_wvalid ? '1 : '0;
        w_pld.last  = w_wvalid;
    end

    assign awvalid_o    = w_awvalid;
    assign wvalid_o     = w_wvalid;
    assign awaddr_o     = w_pld.addr;
    assign awlen_o      = w_pld.awlen;
    assign wdata_o      = w_pld.data;
    assign wstrb_o      = w_pld.strb;
    assign wlast_o      = w_pld.last;
    assign wdfifo_pop_o = w_wvalid & wready_i;
    assign err_o        = r_err;

endmodule

// File: doc/hawk_decomp_pgwr.md
# hawk_decomp_pgwr

Page writer for the decompression path. Once a compressed page is expanded, this block drains the 64 decompressed cachelines from the show-ahead write-data FIFO. It writes them to the free 4 KB way chosen by the decompression manager, using one single-beat AXI4 write per cacheline. It then pulses `done_o`, which the page-write manager uses to raise `zspg_updated` toward the decompression manager.

## Interface
- `ADDR_W`, 64, AXI address width.
- `DATA_W`, 512, AXI data width; one beat is one 64-byte cacheline.
- `LINES`, 64, cachelines per page (4 KB / 64 B).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle request; sampled only in IDLE.
- `dst_base_i` in ADDR_W: destination page byte address; bits [11:0] are ignored.
- `wdfifo_empty_i` in 1: write-data FIFO empty.
- `wdfifo_rdata_i` in DATA_W: FIFO head (show-ahead).
- `wdfifo_pop_o` out 1: pop the FIFO head.
- `awvalid_o` out 1, `awready_i` in 1, `awaddr_o` out ADDR_W, `awlen_o` out 8: AXI write-address channel.
- `wvalid_o` out 1, `wready_i` in 1, `wdata_o` out DATA_W, `wstrb_o` out DATA_W/8, `wlast_o` out 1: AXI write-data channel.
- `bvalid_i` in 1, `bresp_i` in 2, `bready_o` out 1: AXI write-response channel.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse after the last B response.
- `err_o` out 1: sticky; set on a nonzero `bresp_i`.

## Operation
States: IDLE, WR_REQ, WR_RESP, DONE, BUS_ERROR.

- **IDLE**
  - On `start_i`: latch `page_q = dst_base_i[ADDR_W-1:12]`, clear `line_cnt` (6 bits) and both handshake flags, go to WR_REQ.
- **WR_REQ**
  - When `!wdfifo_empty_i`, assert `awvalid_o` and `wvalid_o`.
  - Channel values: `awaddr_o = {page_q, line_cnt, 6'b0}`, `awlen_o = 0`, `wdata_o = wdfifo_rdata_i`, `wstrb_o` all ones, `wlast_o = 1`.
  - `aw_done` / `w_done` flags record each completed handshake. A valid is deasserted once its own flag is set.
  - `wdfifo_pop_o = wvalid_o & wready_i`, exactly one pulse per line.
  - Go to WR_RESP when both handshakes have completed, either in the same cycle or across cycles.
- **WR_RESP**
  - `bready_o = 1`.
  - On `bvalid_i` with `bresp_i == 0`: if `line_cnt == LINES-1`, go to DONE; else increment `line_cnt`, clear the flags, go to WR_REQ.
  - On `bvalid_i` with `bresp_i != 0`: set `err_o`, go to BUS_ERROR.
- **DONE**
  - `done_o = 1` for one cycle, then go to IDLE.
- **BUS_ERROR**
  - Terminal. `busy_o = 1`; only `rst_ni` exits.

Rules:
- Only one write is outstanding at a time.
- Addresses never cross the 4 KB page; `line_cnt` never wraps within a page.

## Timing
- Reset value of every output and register is 0. State resets to IDLE.
- Reset mid-operation aborts immediately. The FIFO is not flushed here; the upstream reset pulse owns that.
- `start_i` while not in IDLE (including DONE) is ignored.
- Valids are Moore outputs of state, flags and `wdfifo_empty_i`; they never depend on `awready_i`, `wready_i` or `bvalid_i`.
- Once asserted, a valid holds until its handshake completes.
- The FIFO cannot go empty while `wvalid_o` is high, because nothing pops before `wready_i`.
- Best case with all readies and `bvalid_i` tied high: 2 cycles per line. `done_o` is high exactly 129 cycles after the cycle `start_i` is sampled.
- FIFO empty in WR_REQ stalls with both valids low; no timeout.
- `bvalid_i` outside WR_RESP is ignored (`bready_o` is low there).

## Structure
- `hacd_pkg` holds the state enum type `pgwr_state_t`, the `LINES` / page-shift constants, and an `axi_wr_pld_t` struct (addr, awlen, data, strb, last) used as the channel payload.
- One sub-module is natural: `hawk_axi_wr_hs`, the per-line AW/W dual-handshake tracker that produces `aw_done`, `w_done` and `both_done`.
- Everything else stays in a single FSM plus a counter.

## Test plan
- **Full page, all readies high:** `start_i` with `dst_base_i = 0x8000_3ABC`, 64 distinct lines preloaded → 64 writes at 0x8000_3000..0x8000_3FC0, data in order, 64 pops, `done_o` at cycle 129, `err_o = 0`.
- **Split handshakes:** `awready_i` 3 cycles before `wready_i` on line 5, and the reverse on line 6 → each address and beat is sent exactly once, one pop per line, no duplicate AW.
- **FIFO starvation:** FIFO empty for 10 cycles before line 20 → valids low for all 10 cycles, write resumes with the correct address 0x…500, total of 64 pops.
- **Error response:** `bresp_i = 2'b10` on line 7 → `err_o = 1`, FSM in BUS_ERROR, no further AW after line 7, `done_o` never asserted; after `rst_ni` all outputs read 0.
- **Ignored start and mid-operation reset:** `start_i` during line 30 is ignored. `rst_ni` asserted at line 40 → IDLE next edge, `busy_o = 0`, `line_cnt = 0`. A new start then writes from line 0.
